// File: rtl/encoder_83_pkg.sv
// Shared constants and payload type for the 8-to-3 priority encoder.
package encoder_83_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  localparam logic [IDX_W-1:0] IDLE_IDX = 3'b000;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             hit;
  } enc_out_t;

endpackage

// File: rtl/encoder_83_core.sv
// Combinational priority chain: highest-numbered asserted request wins.
module encoder_83_core
  import encoder_83_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  // Ascending scan so a later (higher) index overrides lower hits.
  always_comb begin
    idx = IDLE_IDX;
    hit = 1'b0;
    if (en) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) begin
          idx = IDX_W'(i);
          hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/encoder_83.sv
// 8-to-3 priority encoder top: packs request lines and adds an optional output register.
module encoder_83
  import encoder_83_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c0,
  input  logic             c1,
  input  logic             c2,
  input  logic             c3,
  input  logic             c4,
  input  logic             c5,
  input  logic             c6,
  input  logic             c7,
  input  logic             en,
  output logic [IDX_W-1:0] a,
  output logic             valid
);

  logic [N_REQ-1:0] req;
  enc_out_t         enc;

  assign req = {c7, c6, c5, c4, c3, c2, c1, c0};

  encoder_83_core u_core (
    .req (req),
    .en  (en),
    .idx (enc.idx),
    .hit (enc.hit)
  );

  generate
    if (OUT_REG) begin : g_reg
      enc_out_t enc_q;

      // Reset clears the result immediately and drops any pending sample.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          enc_q <= '{idx: IDLE_IDX, hit: 1'b0};
        end else begin
          enc_q <= enc;
        end
      end

      assign a     = enc_q.idx;
      assign valid = enc_q.hit;
    end else begin : g_comb
      assign a     = enc.idx;
      assign valid = enc.hit;
    end
  endgenerate

endmodule

// File: tb/tb_encoder_83.sv
// Directed self-checking bench for encoder_83, registered and bypass builds.
module tb_encoder_83;

  logic       clk;
  logic       rst;
  logic [7:0] c;
  logic       en;
  logic [2:0] a,   a_c;
  logic       valid, valid_c;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  encoder_83 #(.OUT_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .c0(c[0]), .c1(c[1]), .c2(c[2]), .c3(c[3]),
    .c4(c[4]), .c5(c[5]), .c6(c[6]), .c7(c[7]),
    .en(en), .a(a), .valid(valid)
  );

  encoder_83 #(.OUT_REG(1'b0)) dut_comb (
    .clk(clk), .rst(rst),
    .c0(c[0]), .c1(c[1]), .c2(c[2]), .c3(c[3]),
    .c4(c[4]), .c5(c[5]), .c6(c[6]), .c7(c[7]),
    .en(en), .a(a_c), .valid(valid_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] ea, input logic ev);
    n_vec++;
    assert (a === ea && valid === ev)
    else begin
      n_err++;
      $error("FAIL %s: a=%b valid=%b, required a=%b valid=%b", tag, a, valid, ea, ev);
    end
  endtask

  task automatic chk_c(input string tag, input logic [2:0] ea, input logic ev);
    n_vec++;
    assert (a_c === ea && valid_c === ev)
    else begin
      n_err++;
      $error("FAIL %s: a=%b valid=%b, required a=%b valid=%b", tag, a_c, valid_c, ea, ev);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with all requests high: output cleared without any clock edge.
    rst = 1'b1;
    c   = 8'b1111_1111;
    en  = 1'b1;
    #1;
    chk("reset_immediate", 3'd0, 1'b0);
    chk_c("comb_ignores_rst", 3'd7, 1'b1);
    tick();
    tick();
    chk("reset_held", 3'd0, 1'b0);
    rst = 1'b0;
    tick();
    chk("reset_release", 3'd7, 1'b1);

    // Shift-down sweep 11111111 .. 00000001.
    c = 8'b1111_1111; tick(); chk("sweep_ff", 3'd7, 1'b1);
    c = 8'b0111_1111; tick(); chk("sweep_7f", 3'd6, 1'b1);
    c = 8'b0011_1111; tick(); chk("sweep_3f", 3'd5, 1'b1);
    c = 8'b0001_1111; tick(); chk("sweep_1f", 3'd4, 1'b1);
    c = 8'b0000_1111; tick(); chk("sweep_0f", 3'd3, 1'b1);
    c = 8'b0000_0111; tick(); chk("sweep_07", 3'd2, 1'b1);
    c = 8'b0000_0011; tick(); chk("sweep_03", 3'd1, 1'b1);
    c = 8'b0000_0001; tick(); chk("sweep_01", 3'd0, 1'b1);

    // One-hot sweep.
    c = 8'b0000_0001; tick(); chk("onehot_0", 3'd0, 1'b1);
    c = 8'b0000_0010; tick(); chk("onehot_1", 3'd1, 1'b1);
    c = 8'b0000_0100; tick(); chk("onehot_2", 3'd2, 1'b1);
    c = 8'b0000_1000; tick(); chk("onehot_3", 3'd3, 1'b1);
    c = 8'b0001_0000; tick(); chk("onehot_4", 3'd4, 1'b1);
    c = 8'b0010_0000; tick(); chk("onehot_5", 3'd5, 1'b1);
    c = 8'b0100_0000; tick(); chk("onehot_6", 3'd6, 1'b1);
    c = 8'b1000_0000; tick(); chk("onehot_7", 3'd7, 1'b1);
    c = 8'b0000_0000; tick(); chk("no_request", 3'd0, 1'b0);
    chk_c("comb_no_request", 3'd0, 1'b0);

    // Latency: output holds the previous sample until the edge.
    c = 8'b0010_0100;
    #2;
    chk("latency_hold", 3'd0, 1'b0);
    chk_c("comb_zero_latency", 3'd5, 1'b1);
    tick();
    chk("latency_update", 3'd5, 1'b1);

    // Enable gating.
    c  = 8'b1010_0000;
    en = 1'b0;
    tick();
    chk("en_low", 3'd0, 1'b0);
    chk_c("comb_en_low", 3'd0, 1'b0);
    en = 1'b1;
    tick();
    chk("en_high", 3'd7, 1'b1);

    // Async reset between edges discards the result.
    c = 8'b0001_0000;
    tick();
    chk("mid_pre_reset", 3'd4, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_reset", 3'd0, 1'b0);
    tick();
    chk("mid_reset_held", 3'd0, 1'b0);
    rst = 1'b0;
    tick();
    chk("mid_reset_release", 3'd4, 1'b1);

    // Bypass build: combinational result, no clock needed.
    c  = 8'b0000_0110;
    en = 1'b1;
    #1;
    chk_c("comb_06", 3'd2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety bound in case the clock or stimulus stalls.
  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
